// File: rtl/conv_modport.sv
// conv_modport: 64-bit word to byte serializer with 1-word holding buffer; define CONV_MSB_FIRST_EN for MSB-first byte order
module conv_modport (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [63:0] data_in,
  output logic        valid_out,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        overflow
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t      r_state;
  logic [63:0] r_sh, r_buf;
  logic [2:0]  r_cnt;
  logic        r_buf_full;
  logic [63:0] w_src;
  logic        w_last, w_load, w_buf_wr, w_drop, w_buf_full_nxt, w_shift_nxt;
`ifdef CONV_MSB_FIRST_EN
  function automatic logic [7:0] head(input logic [63:0] w);
    return w[63:56];
  endfunction
  function automatic logic [63:0] tail(input logic [63:0] w);
    return w << 8;
  endfunction
`else
  function automatic logic [7:0] head(input logic [63:0] w);
    return w[7:0];
  endfunction
  function automatic logic [63:0] tail(input logic [63:0] w);
    return w >> 8;
  endfunction
`endif
  always_comb begin
    w_last         = r_state == SHIFT && r_cnt == 3'd7;
    w_load         = (r_state == IDLE && valid_in) || (w_last && (r_buf_full || valid_in));
    w_src          = (w_last && r_buf_full) ? r_buf : data_in;
    w_buf_wr       = valid_in && r_state == SHIFT && (w_last ? r_buf_full : !r_buf_full);
    w_drop         = valid_in && r_state == SHIFT && !w_last && r_buf_full;
    w_buf_full_nxt = w_buf_wr ? 1'b1 : (w_last && r_buf_full) ? 1'b0 : r_buf_full;
    w_shift_nxt    = w_load || (r_state == SHIFT && !w_last);
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_sh       <= 64'd0;
      r_buf      <= 64'd0;
      r_buf_full <= 1'b0;
      valid_out  <= 1'b0;
      data_out   <= 8'h00;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      r_state    <= w_shift_nxt ? SHIFT : IDLE;
      r_cnt      <= w_load ? 3'd0 : (r_state == SHIFT ? r_cnt + 3'd1 : r_cnt);
      r_sh       <= w_load ? tail(w_src) : tail(r_sh);
      r_buf      <= w_buf_wr ? data_in : r_buf;
      r_buf_full <= w_buf_full_nxt;
      valid_out  <= w_shift_nxt;
      data_out   <= w_load ? head(w_src) : (w_shift_nxt ? head(r_sh) : 8'h00);
      busy       <= w_shift_nxt || w_buf_full_nxt;
      overflow   <= overflow || w_drop;
    end
  end
endmodule

// File: tb/tb_conv_modport.sv
// tb_conv_modport: directed table, corner sequences and random traffic against a word-queue reference model
module tb_conv_modport;
  logic        clk_in, rst, valid_in, valid_out, busy, overflow;
  logic [63:0] data_in;
  logic [7:0]  data_out;
  int          total, bad, cycn, first, last;
  logic [63:0] q[$];
  logic [7:0]  seen[$];
  int          pos;
  logic        m_ovf;

  conv_modport dut (
    .clk_in(clk_in), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out), .busy(busy), .overflow(overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] mb(input logic [63:0] w, input int k);
`ifdef CONV_MSB_FIRST_EN
    return w[63-8*k -: 8];
`else
    return w[8*k +: 8];
`endif
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [63:0] d);
    if (r) begin
      q.delete();
      pos = 0;
      m_ovf = 1'b0;
    end else begin
      if (q.size() > 0) begin
        pos++;
        if (pos == 8) begin
          q.delete(0);
          pos = 0;
        end
      end
      if (v) begin
        if (q.size() < 2) q.push_back(d);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic cmp(input string name, input logic ev, input logic [7:0] ed, input logic eb, input logic eo);
    total++;
    if (valid_out !== ev || data_out !== ed || busy !== eb || overflow !== eo) begin
      bad++;
      $display("FAIL %s cyc=%0d: got v=%b d=%h b=%b o=%b, want v=%b d=%h b=%b o=%b",
               name, cycn, valid_out, data_out, busy, overflow, ev, ed, eb, eo);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [63:0] d);
    logic ev;
    rst = r;
    valid_in = v;
    data_in = d;
    @(posedge clk_in);
    model_step(r, v, d);
    @(negedge clk_in);
    cycn++;
    ev = q.size() > 0;
    cmp("model", ev, ev ? mb(q[0], pos) : 8'h00, ev, m_ovf);
    if (valid_out === 1'b1) begin
      seen.push_back(data_out);
      if (first < 0) first = cycn;
      last = cycn;
    end
  endtask

  task automatic clr_rec();
    seen.delete();
    first = -1;
    last = -1;
  endtask

  typedef struct {
    logic r; logic v; logic [63:0] d;
    logic ev; logic [7:0] ed; logic eb; logic eo;
  } vec_t;
  vec_t tbl[11];

  localparam logic [63:0] W0 = 64'h0807060504030201;
  localparam logic [63:0] WA = 64'hA7A6A5A4A3A2A1A0;
  localparam logic [63:0] WB = 64'hB7B6B5B4B3B2B1B0;
  localparam logic [63:0] WC = 64'hC7C6C5C4C3C2C1C0;
  localparam logic [63:0] WH = 64'hF0E1D2C3B4A59687;

  function automatic logic [7:0] w0b(input int k);
`ifdef CONV_MSB_FIRST_EN
    return 8'(8 - k);
`else
    return 8'(k + 1);
`endif
  endfunction

  initial begin
    total = 0; bad = 0; cycn = 0; pos = 0; m_ovf = 1'b0;
    rst = 1'b1; valid_in = 1'b0; data_in = 64'd0;
    clr_rec();
    tbl[0] = '{1'b1, 1'b1, W0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, W0, 1'b1, w0b(0), 1'b1, 1'b0};
    for (int i = 2; i <= 8; i++) tbl[i] = '{1'b0, 1'b0, 64'd0, 1'b1, w0b(i - 1), 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 64'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 64'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].r, tbl[i].v, tbl[i].d);
      cmp($sformatf("table[%0d]", i), tbl[i].ev, tbl[i].ed, tbl[i].eb, tbl[i].eo);
    end

    cyc(1, 0, 0);
    clr_rec();
    cyc(0, 1, {8{8'h11}});
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, {8{8'h22}});
    for (int i = 0; i < 20; i++) cyc(0, 0, 0);
    chk("b2b_count", 64'(seen.size()), 64'd16);
    chk("b2b_span", 64'(last - first + 1), 64'd16);
    for (int i = 0; i < seen.size() && i < 16; i++) chk("b2b_byte", 64'(seen[i]), i < 8 ? 64'h11 : 64'h22);
    chk("b2b_ovf", 64'(overflow), 64'd0);

    cyc(1, 0, 0);
    clr_rec();
    cyc(0, 1, WA);
    cyc(0, 1, WB);
    cyc(0, 1, WC);
    chk("ovf_set", 64'(overflow), 64'd1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(seen.size()), 64'd16);
    for (int i = 0; i < seen.size() && i < 16; i++) chk("ovf_byte", 64'(seen[i]), 64'(mb(i < 8 ? WA : WB, i % 8)));
    cyc(0, 1, WC);
    chk("ovf_idle_accept", {55'd0, valid_out, data_out}, {55'd0, 1'b1, mb(WC, 0)});
    for (int i = 0; i < 8; i++) cyc(0, 0, 0);

    cyc(1, 0, 0);
    cyc(0, 1, W0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_mid_3rd", 64'(data_out), 64'(w0b(2)));
    clr_rec();
    cyc(1, 1, WA);
    chk("rst_mid_out", {61'd0, valid_out, busy, overflow}, 64'd0);
    chk("rst_mid_data", 64'(data_out), 64'd0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);
    chk("rst_mid_residual", 64'(seen.size()), 64'd0);

    cyc(1, 0, 0);
    clr_rec();
    cyc(0, 1, W0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0);
    chk("handoff_last", {55'd0, valid_out, data_out}, {55'd0, 1'b1, w0b(7)});
    cyc(0, 1, WH);
    chk("handoff_first", {55'd0, valid_out, data_out}, {55'd0, 1'b1, mb(WH, 0)});
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);
    chk("handoff_span", 64'(last - first + 1), 64'd16);

    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0, {$urandom, $urandom});
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 3, {$urandom, $urandom});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_modport.md
CONV_MODPORT -- requirements
Module: conv_modport

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk_in, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port valid_in, input, 1 bit: data_in holds a 64-bit word to serialize this cycle.
REQ-005 Port data_in, input, 64 bits: parallel input word.
REQ-006 Port valid_out, output, 1 bit: data_out carries a valid byte this cycle.
REQ-007 Port data_out, output, 8 bits: serialized output byte.
REQ-008 Port busy, output, 1 bit: high while the shifter holds an unsent byte or the holding buffer is full.
REQ-009 Port overflow, output, 1 bit: sticky flag for a dropped input word.
REQ-010 All outputs SHALL be registered.

Function
REQ-011 States: IDLE (shifter empty) and SHIFT (shifter holds bytes), plus a 1-word holding buffer (BUF) with a full flag and a 3-bit byte counter.
REQ-012 In IDLE, a word with valid_in=1 SHALL load the shifter, set counter=0 and move to SHIFT.
REQ-013 The first byte SHALL appear on the cycle after capture (latency 1).
REQ-014 Each accepted word SHALL produce exactly 8 consecutive valid_out=1 cycles, one byte per cycle.
REQ-015 Default byte order SHALL be LSB first: data_in[7:0] first and data_in[63:56] last.
REQ-016 In SHIFT with counter<7, valid_in=1 and BUF empty SHALL capture the word into BUF.
REQ-017 In SHIFT with counter<7, valid_in=1 and BUF full SHALL drop the word and set overflow.
REQ-018 On the cycle the 8th byte is output (counter=7), the next state SHALL be selected as follows:
- BUF full: BUF loads into the shifter; if valid_in=1, the new word goes into BUF.
- BUF empty and valid_in=1: the new word loads directly into the shifter.
- Otherwise: return to IDLE.
REQ-019 Back-to-back words SHALL be output with no idle cycle between them (16 consecutive valid bytes for two words).
REQ-020 When valid_out=0, data_out SHALL be 8'h00.
REQ-021 overflow SHALL stay high once set and clear only on reset.
REQ-022 busy SHALL be low only when IDLE with BUF empty.
REQ-023 In IDLE, a word with valid_in=1 SHALL always be accepted, even with overflow set.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL enter the following state on that edge:
- valid_out=0, data_out=8'h00, busy=0, overflow=0.
- Counter=0, BUF empty, state IDLE.
REQ-025 valid_in SHALL be ignored while rst=1.
REQ-026 Reset asserted mid-word SHALL abort serialization immediately, with no residual bytes after reset release.

Configuration
REQ-027 The byte order SHALL be selected by macro CONV_MSB_FIRST_EN:
- Defined: MSB first (data_in[63:56] first, data_in[7:0] last).
- Not defined: LSB first per REQ-015.
- All timing and flags SHALL be identical in both builds.

Verification
REQ-028 Single word: release reset, drive 0x0807060504030201 for one cycle -> bytes 01,02,...,08 on cycles +1..+8, valid_out=1 for exactly 8 cycles, busy low after the last byte.
REQ-029 Back-to-back words: drive 0x1111111111111111 then, 3 cycles later, 0x2222222222222222 -> 8×11 then 8×22 with no gap, overflow=0.
REQ-030 Overflow: drive three words on consecutive cycles (A, B, C) -> A then B output, C dropped, overflow=1 from the cycle after C, still 1 after 20 idle cycles.
REQ-031 Reset mid-word: assert rst after the 3rd byte of 0x0807060504030201 -> valid_out=0, data_out=00, busy=0 on the next cycle, no further bytes.
REQ-032 MSB build with CONV_MSB_FIRST_EN defined: drive 0x0807060504030201 -> bytes 08,07,...,01 with the same timing as REQ-028.
REQ-033 Last-byte handoff: with BUF empty, drive a word exactly on the cycle the 8th byte is output -> its first byte follows with no gap.
